// File: rtl/host_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : host_fifo_arbiter
// Purpose  : Shares one host byte FIFO pair between two clients. Outbound
//            packets are merged atomically (round-robin). Inbound frames are
//            split by header IFACE bit and their payload is queued per client.
// Option   : HOST_FIFO_ARB_IFACE_FORCE_EN overwrites outbound header bit[7]
//            with the granted client index.
// Revision : 1.0 - initial release
// ============================================================================
module host_fifo_arbiter #(
   parameter int TXDEPTH = 8,
   parameter int RXDEPTH = 8
) (
   input  logic            CLK,
   input  logic            RESETn,
   output logic            H_RDEN,
   input  logic            H_RDEMPTY,
   input  logic [7:0]      H_RDDATA,
   output logic            H_WREN,
   input  logic            H_WRFULL,
   output logic [7:0]      H_WRDATA,
   input  logic [1:0]      C_RDEN,
   output logic [1:0]      C_RDEMPTY,
   output logic [1:0][7:0] C_RDDATA,
   input  logic [1:0]      C_WREN,
   output logic [1:0]      C_WRFULL,
   input  logic [1:0][7:0] C_WRDATA
);

   localparam int                c_TXAW   = $clog2(TXDEPTH);
   localparam int                c_RXAW   = $clog2(RXDEPTH);
   localparam logic [c_TXAW-1:0] c_TXP1   = c_TXAW'(1);
   localparam logic [c_RXAW-1:0] c_RXP1   = c_RXAW'(1);
   localparam logic [c_TXAW:0]   c_TXC1   = (c_TXAW+1)'(1);
   localparam logic [c_RXAW:0]   c_RXC1   = (c_RXAW+1)'(1);
   localparam logic [c_TXAW:0]   c_TXFULL = (c_TXAW+1)'(TXDEPTH);
   localparam logic [c_RXAW+1:0] c_RXDEP  = (c_RXAW+2)'(RXDEPTH);

   typedef enum logic [0:0] {TX_IDLE = 1'b0, TX_PKT = 1'b1} tx_state_t;
   typedef enum logic [0:0] {RX_HDR  = 1'b0, RX_PAY = 1'b1} rx_state_t;

   // outbound path
   logic [1:0]            w_txpop;
   logic [1:0]            w_txne;
   logic [1:0][7:0]       w_txhead;
   logic                  w_gnt;
   logic [7:0]            w_hdr;
   logic [7:0]            w_hdr_out;
   tx_state_t             r_txst, w_txst_nx;
   logic                  r_rr, w_rr_nx;
   logic                  r_txsel, w_txsel_nx;
   logic [3:0]            r_rem, w_rem_nx;
   logic                  r_hwren, w_hwren_nx;
   logic [7:0]            r_hwrdata, w_hwrdata_nx;

   // inbound path
   logic [1:0]            w_rxpush;
   logic [1:0][c_RXAW:0]  w_rxcnt;
   logic [c_RXAW+1:0]     w_rxocc;
   logic                  w_rxok;
   rx_state_t             r_rxst, w_rxst_nx;
   logic                  r_rxsel, w_rxsel_nx;
   logic [3:0]            r_rcnt, w_rcnt_nx;
   logic                  r_inflight;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_txq
         logic [7:0]        r_mem [TXDEPTH];
         logic [c_TXAW-1:0] r_wp, r_rp;
         logic [c_TXAW:0]   r_cnt;
         logic              w_push;

         assign w_push = C_WREN[gi] && (r_cnt != c_TXFULL);

         always_ff @(posedge CLK) begin
            if (!RESETn) begin
               r_wp  <= '0;
               r_rp  <= '0;
               r_cnt <= '0;
            end else begin
               if (w_push) begin
                  r_mem[r_wp] <= C_WRDATA[gi];
                  r_wp        <= r_wp + c_TXP1;
               end
               if (w_txpop[gi]) begin
                  r_rp <= r_rp + c_TXP1;
               end
               case ({w_push, w_txpop[gi]})
                  2'b10:   r_cnt <= r_cnt + c_TXC1;
                  2'b01:   r_cnt <= r_cnt - c_TXC1;
                  default: r_cnt <= r_cnt;
               endcase
            end
         end

         assign w_txne[gi]   = (r_cnt != '0);
         assign w_txhead[gi] = r_mem[r_rp];
         assign C_WRFULL[gi] = (r_cnt == c_TXFULL);
      end
   endgenerate

   assign w_gnt = (w_txne == 2'b11) ? r_rr : w_txne[1];
   assign w_hdr = w_txhead[w_gnt];

`ifdef HOST_FIFO_ARB_IFACE_FORCE_EN
   assign w_hdr_out = {w_gnt, w_hdr[6:0]};
`else
   assign w_hdr_out = w_hdr;
`endif

   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         r_txst    <= TX_IDLE;
         r_rr      <= 1'b0;
         r_txsel   <= 1'b0;
         r_rem     <= 4'd0;
         r_hwren   <= 1'b0;
         r_hwrdata <= 8'h00;
      end else begin
         r_txst    <= w_txst_nx;
         r_rr      <= w_rr_nx;
         r_txsel   <= w_txsel_nx;
         r_rem     <= w_rem_nx;
         r_hwren   <= w_hwren_nx;
         r_hwrdata <= w_hwrdata_nx;
      end
   end

   // A granted client keeps the host until its whole packet has been sent
   always_comb begin
      w_txst_nx    = r_txst;
      w_rr_nx      = r_rr;
      w_txsel_nx   = r_txsel;
      w_rem_nx     = r_rem;
      w_txpop      = 2'b00;
      w_hwren_nx   = 1'b0;
      w_hwrdata_nx = r_hwrdata;
      case (r_txst)
         TX_IDLE: begin
            if (!H_WRFULL && (w_txne != 2'b00)) begin
               w_txpop      = w_gnt ? 2'b10 : 2'b01;
               w_hwren_nx   = 1'b1;
               w_hwrdata_nx = w_hdr_out;
               w_rem_nx     = {1'b0, w_hdr[6:4]} + 4'd1;
               w_txsel_nx   = w_gnt;
               w_txst_nx    = TX_PKT;
            end
         end
         TX_PKT: begin
            if (!H_WRFULL && w_txne[r_txsel]) begin
               w_txpop      = r_txsel ? 2'b10 : 2'b01;
               w_hwren_nx   = 1'b1;
               w_hwrdata_nx = w_txhead[r_txsel];
               w_rem_nx     = r_rem - 4'd1;
               if (r_rem == 4'd1) begin
                  w_txst_nx = TX_IDLE;
                  w_rr_nx   = ~r_txsel;
               end
            end
         end
         default: w_txst_nx = TX_IDLE;
      endcase
   end

   assign H_WREN   = r_hwren;
   assign H_WRDATA = r_hwrdata;

   assign w_rxocc = {1'b0, w_rxcnt[r_rxsel]} + {{(c_RXAW+1){1'b0}}, r_inflight};

   always_ff @(posedge CLK) begin
      if (!RESETn) begin
         r_rxst     <= RX_HDR;
         r_rxsel    <= 1'b0;
         r_rcnt     <= 4'd0;
         r_inflight <= 1'b0;
      end else begin
         r_rxst     <= w_rxst_nx;
         r_rxsel    <= w_rxsel_nx;
         r_rcnt     <= w_rcnt_nx;
         r_inflight <= H_RDEN;
      end
   end

   // No read is issued while a header is in flight, so the first payload
   // read already sees the free space of the client the header selects.
   always_comb begin
      w_rxst_nx  = r_rxst;
      w_rxsel_nx = r_rxsel;
      w_rcnt_nx  = r_rcnt;
      w_rxpush   = 2'b00;
      w_rxok     = 1'b0;
      case (r_rxst)
         RX_HDR: begin
            w_rxok = !r_inflight;
            if (r_inflight) begin
               w_rxsel_nx = H_RDDATA[7];
               w_rcnt_nx  = {1'b0, H_RDDATA[6:4]} + 4'd1;
               w_rxst_nx  = RX_PAY;
            end
         end
         RX_PAY: begin
            w_rxok = (w_rxocc < c_RXDEP) && (r_rcnt > {3'b000, r_inflight});
            if (r_inflight) begin
               w_rxpush  = r_rxsel ? 2'b10 : 2'b01;
               w_rcnt_nx = r_rcnt - 4'd1;
               if (r_rcnt == 4'd1) begin
                  w_rxst_nx = RX_HDR;
               end
            end
         end
         default: w_rxst_nx = RX_HDR;
      endcase
   end

   assign H_RDEN = RESETn && !H_RDEMPTY && w_rxok;

   generate
      for (gi = 0; gi < 2; gi++) begin : g_rxq
         logic [7:0]        r_mem [RXDEPTH];
         logic [c_RXAW-1:0] r_wp, r_rp;
         logic [c_RXAW:0]   r_cnt;
         logic [7:0]        r_rdata;
         logic              w_pop;

         assign w_pop = C_RDEN[gi] && (r_cnt != '0);

         always_ff @(posedge CLK) begin
            if (!RESETn) begin
               r_wp    <= '0;
               r_rp    <= '0;
               r_cnt   <= '0;
               r_rdata <= 8'h00;
            end else begin
               if (w_rxpush[gi]) begin
                  r_mem[r_wp] <= H_RDDATA;
                  r_wp        <= r_wp + c_RXP1;
               end
               if (w_pop) begin
                  r_rdata <= r_mem[r_rp];
                  r_rp    <= r_rp + c_RXP1;
               end
               case ({w_rxpush[gi], w_pop})
                  2'b10:   r_cnt <= r_cnt + c_RXC1;
                  2'b01:   r_cnt <= r_cnt - c_RXC1;
                  default: r_cnt <= r_cnt;
               endcase
            end
         end

         assign w_rxcnt[gi]   = r_cnt;
         assign C_RDEMPTY[gi] = (r_cnt == '0);
         assign C_RDDATA[gi]  = r_rdata;
      end
   endgenerate

endmodule
`default_nettype wire
